// File: rtl/tt_um_emern_video_pkg.sv
// Shared raster timing constants for the emern video timing generator.
// Holds the VGA 640x480@60 defaults, derived totals and sync window edges,
// and the width of the rrggbb colour output.
package tt_um_emern_video_pkg;

  // Horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Default counter and frame counter widths
  localparam int VGA_CW   = 10;
  localparam int VGA_FC_W = 8;

  // Colour output is two bits each of red, green and blue
  localparam int COLOUR_W = 6;

  // Total period of one axis: visible + front porch + sync + back porch
  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position of the sync pulse on an axis
  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  // Last position of the sync pulse on an axis
  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  // Derived VGA values, handy for the pixel core and for reference
  localparam int VGA_H_TOTAL      = raster_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL      = raster_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  localparam int VGA_H_SYNC_START = sync_first(VGA_H_ACTIVE, VGA_H_FP);
  localparam int VGA_H_SYNC_END   = sync_last(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
  localparam int VGA_V_SYNC_START = sync_first(VGA_V_ACTIVE, VGA_V_FP);
  localparam int VGA_V_SYNC_END   = sync_last(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

endpackage

// File: rtl/tt_um_emern_wrap_counter.sv
// Modulo counter 0..MAX with enable, used for both raster axes.
// Resets asynchronously to MAX so the first enabled step lands on 0.
// o_next exposes the value the counter takes on the coming edge, which lets
// the parent register its decodes in step with the count.
module tt_um_emern_wrap_counter
  import tt_um_emern_video_pkg::*;
#(
  parameter int           W   = VGA_CW,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  // Next value: hold when disabled, otherwise step and wrap after MAX
  always_comb begin
    w_at_max = (r_count == MAX);
    o_wrap   = i_en & w_at_max;
    o_next   = r_count;
    if (i_en) begin
      o_next = w_at_max ? '0 : r_count + 1'b1;
    end
  end

  // Count register, parked at MAX while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= MAX;
    end else begin
      r_count <= o_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tt_um_emern_video_timing.sv
// Raster timing generator: column/row counters, de/hsync/vsync decode and
// line/frame/vblank strobes, all registered so they line up with the counters.
// Optional frame counter is built only when EMERN_FRAME_CNT_EN is defined;
// otherwise frame_cnt is tied to zero and the port list is unchanged.
module tt_um_emern_video_timing
  import tt_um_emern_video_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = VGA_CW,
  parameter int FC_W      = VGA_FC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_ce,
  output logic [CW-1:0]   pixel_col,
  output logic [CW-1:0]   pixel_row,
  output logic            de,
  output logic            hsync,
  output logic            vsync,
  output logic            line_start,
  output logic            frame_start,
  output logic            vblank_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S = CW'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] H_SYNC_E = CW'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] V_SYNC_S = CW'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] V_SYNC_E = CW'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  // Refuse to build when a full line or frame cannot be counted in CW bits
  if ((H_TOTAL > 2**CW) || (V_TOTAL > 2**CW)) begin : g_cw_too_small
    $error("tt_um_emern_video_timing: H_TOTAL or V_TOTAL exceeds 2**CW");
  end

  logic [CW-1:0] w_col;
  logic [CW-1:0] w_col_nxt;
  logic [CW-1:0] w_row;
  logic [CW-1:0] w_row_nxt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_v_en;

  logic          w_de_nxt;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;
  logic          w_line_nxt;
  logic          w_frame_nxt;
  logic          w_vblank_nxt;

  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_line_start;
  logic          r_frame_start;
  logic          r_vblank_start;

  tt_um_emern_wrap_counter #(
    .W   (CW),
    .MAX (H_MAX)
  ) u_h_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (pix_ce),
    .o_count (w_col),
    .o_next  (w_col_nxt),
    .o_wrap  (w_h_wrap)
  );

  assign w_v_en = pix_ce & w_h_wrap;

  tt_um_emern_wrap_counter #(
    .W   (CW),
    .MAX (V_MAX)
  ) u_v_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_v_en),
    .o_count (w_row),
    .o_next  (w_row_nxt),
    .o_wrap  (w_v_wrap)
  );

  // Decode the position the counters are about to take
  always_comb begin
    w_de_nxt     = 1'b0;
    w_hsync_nxt  = ~HSYNC_POL;
    w_vsync_nxt  = ~VSYNC_POL;
    w_line_nxt   = 1'b0;
    w_frame_nxt  = 1'b0;
    w_vblank_nxt = 1'b0;
    if ((w_col_nxt < H_ACT) && (w_row_nxt < V_ACT)) begin
      w_de_nxt = 1'b1;
    end
    if ((w_col_nxt >= H_SYNC_S) && (w_col_nxt <= H_SYNC_E)) begin
      w_hsync_nxt = HSYNC_POL;
    end
    if ((w_row_nxt >= V_SYNC_S) && (w_row_nxt <= V_SYNC_E)) begin
      w_vsync_nxt = VSYNC_POL;
    end
    if (pix_ce && (w_col_nxt == '0)) begin
      w_line_nxt   = 1'b1;
      w_frame_nxt  = (w_row_nxt == '0);
      w_vblank_nxt = (w_row_nxt == V_ACT);
    end
  end

  // Level outputs update only when the raster moves, otherwise they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de    <= 1'b0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
    end else if (pix_ce) begin
      r_de    <= w_de_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
    end
  end

  // Strobes load every clock so they drop after one cycle even while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_line_start   <= w_line_nxt;
      r_frame_start  <= w_frame_nxt;
      r_vblank_start <= w_vblank_nxt;
    end
  end

`ifdef EMERN_FRAME_CNT_EN
  logic [FC_W-1:0] r_frame_cnt;

  // Count frames, stepping on the same edge that raises frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_nxt) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign pixel_col    = w_col;
  assign pixel_row    = w_row;
  assign de           = r_de;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;

  // The frame wrap is also visible as frame_start, so it has no other use here
  logic w_unused;
  assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_tt_um_emern_video_timing.sv
// Bench for tt_um_emern_video_timing using a reduced raster so several full
// frames fit in a short run. Honours EMERN_FRAME_CNT_EN the same way as the design.
module tb_tt_um_emern_video_timing;

  localparam int HA = 20, HF = 4, HS = 6, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 3, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int CW = 10;
  localparam int FC_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pix_ce = 1'b0;
  logic [CW-1:0]   pixel_col;
  logic [CW-1:0]   pixel_row;
  logic            de, hsync, vsync;
  logic            line_start, frame_start, vblank_start;
  logic [FC_W-1:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Behavioural model: raster position plus strobe flags and frame count
  int mCol = HT - 1;
  int mRow = VT - 1;
  bit mLs = 1'b0, mFs = 1'b0, mVb = 1'b0;
  int mFrames = 0;
  int nc, nr;

  tt_um_emern_video_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
    .CW (CW), .FC_W (FC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_ce       (pix_ce),
    .pixel_col    (pixel_col),
    .pixel_row    (pixel_row),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .vblank_start (vblank_start),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Model advances one raster position per enabled clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCol <= HT - 1;
      mRow <= VT - 1;
      mLs <= 1'b0;
      mFs <= 1'b0;
      mVb <= 1'b0;
      mFrames <= 0;
    end else if (pix_ce) begin
      nc = (mCol + 1) % HT;
      nr = (nc == 0) ? (mRow + 1) % VT : mRow;
      mCol <= nc;
      mRow <= nr;
      mLs <= (nc == 0);
      mFs <= (nc == 0) && (nr == 0);
      mVb <= (nc == 0) && (nr == VA);
      if ((nc == 0) && (nr == 0)) mFrames <= mFrames + 1;
    end else begin
      mLs <= 1'b0;
      mFs <= 1'b0;
      mVb <= 1'b0;
    end
  end

  task automatic cmpVal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    int expFc;
    cmpVal("col", pixel_col, mCol);
    cmpVal("row", pixel_row, mRow);
    cmpVal("de", de, int'((mCol < HA) && (mRow < VA)));
    cmpVal("hsync", hsync, int'(!((mCol >= HA + HF) && (mCol < HA + HF + HS))));
    cmpVal("vsync", vsync, int'(!((mRow >= VA + VF) && (mRow < VA + VF + VS))));
    cmpVal("line_start", line_start, int'(mLs));
    cmpVal("frame_start", frame_start, int'(mFs));
    cmpVal("vblank_start", vblank_start, int'(mVb));
`ifdef EMERN_FRAME_CNT_EN
    expFc = mFrames % (1 << FC_W);
`else
    expFc = 0;
`endif
    cmpVal("frame_cnt", frame_cnt, expFc);
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Drive pix_ce, let one rising edge happen, return just after it
  task automatic applyStimulus(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  // Run with pix_ce high until the model reaches (col,row); row<0 means any row
  task automatic waitModel(input int col, input int row, input int budget);
    int n;
    n = 0;
    while (!((mCol == col) && ((row < 0) || (mRow == row))) && (n < budget)) begin
      applyStimulus(1'b1);
      n++;
    end
    if (!((mCol == col) && ((row < 0) || (mRow == row)))) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_pos: reached (%0d,%0d), required (%0d,%0d)", mCol, mRow, col, row);
    end
  endtask

  initial begin
    int lowCnt;
    int lsCnt;
    int expFc;

    rst_n = 1'b0;
    pix_ce = 1'b0;
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1);
    applyStimulus(1'b0);

    // Reset values
    cmpVal("rst_col", pixel_col, 31);
    cmpVal("rst_row", pixel_row, 19);
    cmpVal("rst_de", de, 0);
    cmpVal("rst_hsync", hsync, 1);
    cmpVal("rst_vsync", vsync, 1);
    cmpVal("rst_frame_start", frame_start, 0);

    // First enabled clock after release lands on (0,0) with both strobes
    rst_n = 1'b1;
    applyStimulus(1'b1);
    cmpVal("first_col", pixel_col, 0);
    cmpVal("first_row", pixel_row, 0);
    cmpVal("first_de", de, 1);
    cmpVal("first_frame_start", frame_start, 1);
    cmpVal("first_line_start", line_start, 1);

    // hsync low for exactly HS enabled clocks starting at col 24
    waitModel(23, -1, 200);
    cmpVal("hsync_before", hsync, 1);
    lowCnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1);
      if (hsync == 1'b0) lowCnt++;
      if (i == 0) cmpVal("hsync_first_low", hsync, 0);
    end
    cmpVal("hsync_low_len", lowCnt, 6);

    // Entry to the first blanking row
    waitModel(31, 11, 1000);
    applyStimulus(1'b1);
    cmpVal("vb_row", pixel_row, 12);
    cmpVal("vb_col", pixel_col, 0);
    cmpVal("vb_de", de, 0);
    cmpVal("vb_line_start", line_start, 1);
    cmpVal("vb_vblank_start", vblank_start, 1);
    cmpVal("vb_frame_start", frame_start, 0);

    // vsync low on rows 15 and 16 only
    waitModel(31, 14, 1000);
    cmpVal("vsync_row14", vsync, 1);
    waitModel(0, 15, 100);
    cmpVal("vsync_row15", vsync, 0);
    waitModel(31, 16, 100);
    cmpVal("vsync_row16", vsync, 0);
    waitModel(0, 17, 100);
    cmpVal("vsync_row17", vsync, 1);

    // Half-rate pix_ce across a line wrap
    waitModel(29, -1, 100);
    lsCnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i % 2 == 0);
      if (line_start) lsCnt++;
    end
    cmpVal("toggle_line_start_cnt", lsCnt, 1);
    cmpVal("toggle_col", pixel_col, 1);

    // Random enable pattern
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in mid-frame, checked before any clock edge
    waitModel(10, 5, 2000);
    #2;
    rst_n = 1'b0;
    #1;
    cmpVal("async_col", pixel_col, 31);
    cmpVal("async_row", pixel_row, 19);
    cmpVal("async_de", de, 0);
    cmpVal("async_hsync", hsync, 1);
    cmpVal("async_line_start", line_start, 0);
    cmpVal("async_frame_cnt", frame_cnt, 0);
    applyStimulus(1'b1);
    cmpVal("held_rst_col", pixel_col, 31);
    rst_n = 1'b1;
    applyStimulus(1'b1);
    cmpVal("resume_col", pixel_col, 0);
    cmpVal("resume_row", pixel_row, 0);
    cmpVal("resume_frame_start", frame_start, 1);

    // Five frame starts: the 2-bit counter has wrapped to 1
    for (int i = 0; i < 2570; i++) begin
      applyStimulus(1'b1);
    end
`ifdef EMERN_FRAME_CNT_EN
    expFc = 1;
`else
    expFc = 0;
`endif
    cmpVal("frame_cnt_after5", frame_cnt, expFc);

    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
